// File: rtl/newhope_decrypter.sv
// NewHope-512 message recovery: threshold-decodes 512 noisy coefficients into a 256-bit message.
// Optional macro NEWHOPE_DEC_BUSY_EN adds a 'busy' output that is high while decoding.
module newhope_decrypter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  input  logic [7:0]  dia,
  input  logic        wea,
  input  logic [9:0]  addra,
  input  logic [2:0]  addr_out,
  output logic [31:0] do_out
`ifdef NEWHOPE_DEC_BUSY_EN
  ,
  output logic        busy
`endif
);

  localparam logic signed [15:0] Q_HALF = 16'sd6144;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [255:0] msg_q, msg_d;
  logic [31:0]  do_out_q, do_out_d;

  logic [15:0]  mem_l [256];
  logic [15:0]  mem_h [256];
  logic [15:0]  rd_l_q, rd_h_q;

  logic signed [15:0] diff_a, diff_b, abs_a, abs_b, t_sum;
  logic               dec_bit;
  logic [7:0]         bit_idx;
  logic [7:0]         word_base;

  // Coefficient banks: byte writes only outside RUN, read port follows the decode counter.
  always_ff @(posedge clk) begin
    if (wea && (state_q != RUN)) begin
      if (addra[9]) begin
        if (addra[0]) mem_h[addra[8:1]][15:8] <= dia;
        else          mem_h[addra[8:1]][7:0]  <= dia;
      end else begin
        if (addra[0]) mem_l[addra[8:1]][15:8] <= dia;
        else          mem_l[addra[8:1]][7:0]  <= dia;
      end
    end
    rd_l_q <= mem_l[cnt_q[7:0]];
    rd_h_q <= mem_h[cnt_q[7:0]];
  end

  always_comb begin
    diff_a  = signed'({2'b00, rd_l_q[13:0]}) - Q_HALF;
    diff_b  = signed'({2'b00, rd_h_q[13:0]}) - Q_HALF;
    abs_a   = (diff_a < 0) ? -diff_a : diff_a;
    abs_b   = (diff_b < 0) ? -diff_b : diff_b;
    t_sum   = abs_a + abs_b;
    dec_bit = (t_sum < Q_HALF);
  end

  // The read issued with counter value c lands in rd_*_q one edge later, so it decodes bit c-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    msg_d     = msg_q;
    bit_idx   = cnt_q[7:0] - 8'd1;
    word_base = {addr_out, 5'b00000};
    do_out_d  = msg_q[word_base +: 32];
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
          msg_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 9'd1;
        if ((cnt_q != 9'd0) && (cnt_q <= 9'd256)) msg_d[bit_idx] = dec_bit;
        if (cnt_q == 9'd257) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      msg_q    <= '0;
      do_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      msg_q    <= msg_d;
      do_out_q <= do_out_d;
    end
  end

  assign done   = done_q;
  assign do_out = do_out_q;

`ifdef NEWHOPE_DEC_BUSY_EN
  logic busy_q, busy_d;

  always_comb busy_d = (state_d == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= 1'b0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_newhope_decrypter.sv
// Self-checking bench for newhope_decrypter: randomized coefficients against an arithmetic decode model.
module tb_newhope_decrypter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic [7:0]  dia;
  logic        wea;
  logic [9:0]  addra;
  logic [2:0]  addr_out;
  logic [31:0] do_out;
`ifdef NEWHOPE_DEC_BUSY_EN
  logic        busy;
`endif

  int checks;
  int failures;
  int coef [512];

  newhope_decrypter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .dia      (dia),
    .wea      (wea),
    .addra    (addra),
    .addr_out (addr_out),
`ifdef NEWHOPE_DEC_BUSY_EN
    .busy     (busy),
`endif
    .do_out   (do_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: plain integer arithmetic over the 14-bit masked coefficients.
  function automatic logic [255:0] model_msg();
    logic [255:0] m;
    int a, b, t;
    m = '0;
    for (int i = 0; i < 256; i++) begin
      a = coef[i] & 16383;
      b = coef[i + 256] & 16383;
      t = ((a > 6144) ? a - 6144 : 6144 - a) + ((b > 6144) ? b - 6144 : 6144 - b);
      m[i] = (t < 6144);
    end
    return m;
  endfunction

  task automatic write_coef(input int idx, input int val);
    @(negedge clk);
    wea   = 1'b1;
    addra = 10'(idx * 2);
    dia   = 8'(val);
    @(negedge clk);
    addra = 10'(idx * 2 + 1);
    dia   = 8'(val >> 8);
    @(negedge clk);
    wea   = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 512; i++) write_coef(i, coef[i]);
  endtask

  task automatic read_word(input int k, output logic [31:0] w);
    @(negedge clk);
    addr_out = 3'(k);
    @(posedge clk);
    #1;
    w = do_out;
  endtask

  // Pulses start and counts edges until done; optionally disturbs the run with start/wea at edge 50.
  task automatic run_decode(input bit inject, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (inject && lat == 50) begin
        start = 1'b1;
        wea   = 1'b1;
        addra = 10'($urandom);
        dia   = 8'($urandom);
      end else if (inject && lat == 51) begin
        start = 1'b0;
        wea   = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done got=%b want=0", done);
    end
    checks++;
    if (do_out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_do_out got=%h want=00000000", do_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      read_word(k, w);
      checks++;
      if (w !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_word%0d got=%h want=00000000", k, w);
      end
    end
  endtask

  task automatic test_uniform(input int val, input logic [31:0] want);
    logic [31:0] w;
    int lat;
    for (int i = 0; i < 512; i++) coef[i] = val;
    load_all();
    run_decode(1'b0, lat);
    checks++;
    if (lat != 258) begin
      failures++;
      $display("[TB] FAIL uniform_latency val=%0d got=%0d want=258", val, lat);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(k, w);
      checks++;
      if (w !== want) begin
        failures++;
        $display("[TB] FAIL uniform_word%0d val=%0d got=%h want=%h", k, val, w, want);
      end
    end
  endtask

  task automatic test_pattern();
    logic [31:0] w, want;
    logic [7:0]  mbyte;
    int lat;
    for (int i = 0; i < 256; i++) begin
      mbyte = 8'(i >> 3);
      coef[i]       = mbyte[i & 7] ? 6144 : 0;
      coef[i + 256] = coef[i];
    end
    load_all();
    run_decode(1'b0, lat);
    for (int k = 0; k < 8; k++) begin
      want = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
      read_word(k, w);
      checks++;
      if (w !== want) begin
        failures++;
        $display("[TB] FAIL pattern_word%0d got=%h want=%h", k, w, want);
      end
    end
  endtask

  task automatic test_threshold();
    logic [31:0] w;
    int lat;
    for (int i = 0; i < 512; i++) coef[i] = 0;
    coef[0]   = 3072;
    coef[256] = 9216;
    load_all();
    run_decode(1'b0, lat);
    read_word(0, w);
    checks++;
    if (w !== 32'h0) begin
      failures++;
      $display("[TB] FAIL thresh_t6144 got=%h want=00000000", w);
    end
    write_coef(256, 9215);
    run_decode(1'b0, lat);
    checks++;
    if (lat != 258) begin
      failures++;
      $display("[TB] FAIL thresh_latency got=%0d want=258", lat);
    end
    read_word(0, w);
    checks++;
    if (w !== 32'h1) begin
      failures++;
      $display("[TB] FAIL thresh_t6143 got=%h want=00000001", w);
    end
  endtask

  task automatic randomize_coefs();
    for (int i = 0; i < 512; i++) begin
      coef[i] = 6144 + int'($urandom_range(0, 8000)) - 4000;
      if ($urandom_range(0, 7) == 0) coef[i] = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) coef[i] = coef[i] | (int'($urandom_range(0, 3)) << 14);
    end
  endtask

  task automatic test_random(input bit inject);
    logic [255:0] exp;
    logic [31:0]  w;
    int lat;
    randomize_coefs();
    load_all();
    exp = model_msg();
    run_decode(inject, lat);
    checks++;
    if (lat != 258) begin
      failures++;
      $display("[TB] FAIL random_latency inject=%0d got=%0d want=258", inject, lat);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(k, w);
      checks++;
      if (w !== exp[k * 32 +: 32]) begin
        failures++;
        $display("[TB] FAIL random_word%0d inject=%0d got=%h want=%h", k, inject, w, exp[k * 32 +: 32]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] exp;
    logic [31:0]  w;
    int lat;
    randomize_coefs();
    load_all();
    exp = model_msg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || do_out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_state got done=%b do_out=%h want done=0 do_out=00000000", done, do_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      read_word(k, w);
      checks++;
      if (w !== 32'h0) begin
        failures++;
        $display("[TB] FAIL midreset_word%0d got=%h want=00000000", k, w);
      end
    end
    run_decode(1'b0, lat);
    checks++;
    if (lat != 258) begin
      failures++;
      $display("[TB] FAIL midreset_latency got=%0d want=258", lat);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(k, w);
      checks++;
      if (w !== exp[k * 32 +: 32]) begin
        failures++;
        $display("[TB] FAIL midreset_rerun_word%0d got=%h want=%h", k, w, exp[k * 32 +: 32]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    wea      = 1'b0;
    dia      = '0;
    addra    = '0;
    addr_out = '0;
    test_reset();
    test_uniform(6144, 32'hFFFF_FFFF);
    test_uniform(0, 32'h0000_0000);
    test_pattern();
    test_threshold();
    test_random(1'b0);
    test_random(1'b0);
    test_random(1'b1);
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/newhope_decrypter.md
Name: newhope_decrypter

Overview:
- Message-recovery stage of the NewHope-512 decrypter.
- Accepts the noisy polynomial (v' − u·s, 512 coefficients mod q) as a little-endian byte stream.
- Decodes the 256-bit message with the NewHope threshold rule.
- Exposes the result as eight 32-bit words; sits between the polynomial arithmetic and the host readout port.

Parameters:
- Q, 12289, modulus; Q_HALF = Q/2 (integer) = 6144 is the decode threshold and centre.
- N, 512, coefficient count; only 512 supported (two coefficients per message bit).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begins decode
- done  output  1  high when message valid
- dia  input  8  coefficient byte to write
- wea  input  1  write enable for dia
- addra  input  10  byte address: coefficient addra[9:1], low byte if addra[0]=0 else high byte
- addr_out  input  3  message word select
- do_out  output  32  message word

Behaviour:
- Reset (rst=0, asynchronous): FSM→IDLE, done=0, message register=0, do_out=0; coefficient RAM not cleared.
- Coefficient store: two 256x16 banks; coefficients 0..255 in bank L, 256..511 in bank H. Byte write is synchronous on wea=1 in IDLE or DONE; wea ignored in RUN.
- Coefficient value = 16-bit word masked to 14 bits; values ≥ Q are not reduced.
- FSM: IDLE → (start) RUN → DONE → (start) RUN. start is ignored in RUN.
- start in IDLE or DONE: done drops next edge, index i=0, message register cleared.
- RUN: synchronous read of L[i] and H[i] (i = 0..255), one pair per cycle, one pipeline stage.
- For pair a=L[i], b=H[i]: t = |a−Q_HALF| + |b−Q_HALF| (16-bit signed arithmetic, no overflow since max 20478).
- Message bit i = 1 iff t < Q_HALF, else 0.
- Bit i goes to message byte i>>3, bit position i&7.
- done rises exactly 258 rising edges after the edge that samples start, and stays high until the next start or reset.
- Readout: do_out = {byte[4k+3], byte[4k+2], byte[4k+1], byte[4k]} for k=addr_out; registered, one-cycle latency, readable in any state.
- Reads during RUN return partially built data; no guarantee.
- Reset mid-RUN aborts immediately; the next start recomputes from the current RAM contents.

Optional Feature:
- Macro NEWHOPE_DEC_BUSY_EN.
- Defined: adds output port busy (1 bit), high exactly while FSM is in RUN, 0 at reset.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset then read addr_out 0..7 -> do_out=0x00000000 each, done=0.
- All 512 coefficients = 6144, pulse start -> done after 258 cycles; all words 0xFFFFFFFF.
- All coefficients = 0 (t=12288) -> all words 0x00000000.
- For m bytes 00,01,...,1F: coeff i and i+256 = 6144 where bit i of m is set, else 0 -> words 0x03020100, 0x07060504, ..., 0x1F1E1D1C.
- Threshold, all other coefficients 0:
  - c0=3072, c256=9216 (t=6144) -> word0 = 0x00000000.
  - c256=9215 (t=6143) -> word0 = 0x00000001.
- Robustness:
  - Second start and wea pulses during RUN -> ignored, result unchanged, done still at cycle 258.
  - rst=0 at cycle 100 of RUN -> done=0, words 0; a fresh start then gives the correct result.
